// File: rtl/serial_adder_if.sv
// Handshake/operand bundle for serial_adder; the optional `sub` member exists
// only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
      output sub,
`endif
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
      input  sub,
`endif
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell plus a registered carry, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the `sub` member (a - b, cout=1 means no borrow).
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   serial_adder_if.slave bus
);
   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("serial_adder: WIDTH must be in 1..32");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] ra_q;
   logic [WIDTH-1:0] rb_q;
   logic [WIDTH-1:0] res_q;
   logic             c_q;
   logic             cout_q;
   logic [CW-1:0]    cnt_q;

   logic             busy;
   logic             done;
   logic             accept;
   logic             last_bit;
   logic             fa_sum;
   logic             fa_cout;
   logic [WIDTH-1:0] b_load;
   logic             c_load;

   // Subtraction is a + ~b + 1, so only the loaded operand and carry differ.
`ifdef SERIAL_ADDER_SUB_EN
   assign b_load = bus.sub ? ~bus.b : bus.b;
   assign c_load = bus.sub | bus.cin;
`else
   assign b_load = bus.b;
   assign c_load = bus.cin;
`endif

   full_adder u_fa (
      .a    (ra_q[0]),
      .b    (rb_q[0]),
      .cin  (c_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign accept   = bus.start & ~busy;
   assign last_bit = (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (last_bit) state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = bus.start ? S_RUN : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         ra_q   <= '0;
         rb_q   <= '0;
         res_q  <= '0;
         c_q    <= 1'b0;
         cout_q <= 1'b0;
         cnt_q  <= '0;
      end else if (accept) begin
         ra_q  <= bus.a;
         rb_q  <= b_load;
         c_q   <= c_load;
         cnt_q <= '0;
      end else if (busy) begin
         ra_q  <= ra_q >> 1;
         rb_q  <= rb_q >> 1;
         c_q   <= fa_cout;
         res_q <= (res_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
         cnt_q <= cnt_q + CW'(1);
         if (last_bit) cout_q <= fa_cout;
      end
   end

   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.sum  = res_q;
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst;
   logic cur_sub = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(WIDTH)) bus ();

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // {cout, sum} from plain arithmetic on the operands.
   function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin, input logic sub);
      int total;
      if (sub) return {a >= b, 8'((int'(a) - int'(b)) & 255)};
      total = int'(a) + int'(b) + int'(cin);
      return 9'(total);
   endfunction

   // Issues one operation, scrambles the inputs while it runs, waits for done.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output logic [7:0] s, output logic co,
                        output int lat, output int busy_cnt);
      bus.a     = a;
      bus.b     = b;
      bus.cin   = cin;
`ifdef SERIAL_ADDER_SUB_EN
      bus.sub   = cur_sub;
`endif
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      lat       = 0;
      busy_cnt  = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         if (bus.busy === 1'b1) busy_cnt++;
         bus.a   = 8'($urandom);
         bus.b   = 8'($urandom);
         bus.cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
         bus.sub = 1'($urandom);
`endif
         tick();
         lat++;
      end
      s  = bus.sum;
      co = bus.cout;
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.a     = 8'hAA;
      bus.b     = 8'h55;
      bus.cin   = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      rst = 1'b0;
      n_vec++;
      if ({bus.busy, bus.done, bus.cout, bus.sum} !== 11'd0) begin
         n_err++;
         $display("FAIL reset_state: busy=%b done=%b cout=%b sum=%h, want all zero",
                  bus.busy, bus.done, bus.cout, bus.sum);
      end
   endtask

   task automatic test_basic_add;
      logic [7:0] s;
      logic       co;
      int         lat, bc;
      do_op(8'h5A, 8'h3C, 1'b0, s, co, lat, bc);
      n_vec++;
      if ({co, s} !== 9'h096 || lat != 8 || bc != 8) begin
         n_err++;
         $display("FAIL basic_add: sum=%h cout=%b lat=%0d busy_cycles=%0d, want 96/0/8/8",
                  s, co, lat, bc);
      end
      n_vec++;
      if (bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL basic_busy_in_done: busy=%b, want 0", bus.busy);
      end
      tick();
      n_vec++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sum !== 8'h96) begin
         n_err++;
         $display("FAIL done_one_cycle: done=%b busy=%b sum=%h, want 0/0/96",
                  bus.done, bus.busy, bus.sum);
      end
   endtask

   task automatic test_carry;
      logic [7:0] ta [2] = '{8'hFF, 8'hFF};
      logic [7:0] tb [2] = '{8'h01, 8'hFF};
      logic       tc [2] = '{1'b0, 1'b1};
      logic [8:0] tx [2] = '{9'h100, 9'h1FF};
      for (int i = 0; i < 2; i++) begin
         logic [7:0] s;
         logic       co;
         int         lat, bc;
         do_op(ta[i], tb[i], tc[i], s, co, lat, bc);
         n_vec++;
         if ({co, s} !== tx[i] || lat != 8) begin
            n_err++;
            $display("FAIL carry_%0d: {cout,sum}=%h lat=%0d, want %h lat=8", i, {co, s}, lat, tx[i]);
         end
      end
   endtask

   task automatic test_ignored_start;
      int k = 0;
      int extra_done = 0;
      int extra_busy = 0;
      bus.a     = 8'h5A;
      bus.b     = 8'h3C;
      bus.cin   = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      while (bus.done !== 1'b1 && k < 40) begin
         if (k == 3) begin
            bus.start = 1'b1;
            bus.a     = 8'h11;
            bus.b     = 8'h22;
         end else begin
            bus.start = 1'b0;
         end
         tick();
         k++;
      end
      bus.start = 1'b0;
      n_vec++;
      if (k != 8 || bus.sum !== 8'h96 || bus.cout !== 1'b0) begin
         n_err++;
         $display("FAIL ignored_start: lat=%0d sum=%h cout=%b, want 8/96/0", k, bus.sum, bus.cout);
      end
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.done === 1'b1) extra_done++;
         if (bus.busy === 1'b1) extra_busy++;
      end
      n_vec++;
      if (extra_done != 0 || extra_busy != 0) begin
         n_err++;
         $display("FAIL ignored_start_quiet: extra done=%0d busy=%0d, want 0/0", extra_done, extra_busy);
      end
   endtask

   task automatic test_back_to_back;
      int n_done = 0;
      bus.a     = 8'h01;
      bus.b     = 8'h02;
      bus.cin   = 1'b0;
      bus.start = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         tick();
         if (bus.done === 1'b1) begin
            n_vec++;
            if (cyc != 8 + 9 * n_done || bus.sum !== 8'h03 || bus.cout !== 1'b0 || bus.busy !== 1'b0) begin
               n_err++;
               $display("FAIL back_to_back_%0d: cycle=%0d sum=%h cout=%b busy=%b, want %0d/03/0/0",
                        n_done, cyc, bus.sum, bus.cout, bus.busy, 8 + 9 * n_done);
            end
            n_done++;
         end
      end
      bus.start = 1'b0;
      n_vec++;
      if (n_done != 4) begin
         n_err++;
         $display("FAIL back_to_back_count: done pulses=%0d, want 4", n_done);
      end
      for (int i = 0; i < 12; i++) tick();
   endtask

   task automatic test_reset_mid;
      logic [7:0] s;
      logic       co;
      int         lat, bc;
      int         stray = 0;
      do_op(8'hFF, 8'h01, 1'b0, s, co, lat, bc);
      n_vec++;
      if ({co, s} !== 9'h100) begin
         n_err++;
         $display("FAIL pre_reset_op: {cout,sum}=%h, want 100", {co, s});
      end
      bus.a     = 8'h5A;
      bus.b     = 8'h3C;
      bus.cin   = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_vec++;
      if ({bus.busy, bus.done, bus.cout, bus.sum} !== 11'd0) begin
         n_err++;
         $display("FAIL reset_mid: busy=%b done=%b cout=%b sum=%h, want all zero",
                  bus.busy, bus.done, bus.cout, bus.sum);
      end
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.done === 1'b1 || bus.busy === 1'b1) stray++;
      end
      n_vec++;
      if (stray != 0) begin
         n_err++;
         $display("FAIL reset_mid_no_done: active cycles=%0d, want 0", stray);
      end
      do_op(8'h10, 8'h20, 1'b0, s, co, lat, bc);
      n_vec++;
      if ({co, s} !== 9'h030 || lat != 8) begin
         n_err++;
         $display("FAIL after_reset_op: {cout,sum}=%h lat=%0d, want 030/8", {co, s}, lat);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         logic [7:0] a, b, s;
         logic       cin, co;
         logic [8:0] exp;
         int         lat, bc, gap;
         a   = 8'($urandom);
         b   = 8'($urandom);
         cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
         cur_sub = 1'($urandom);
`endif
         exp = model(a, b, cin, cur_sub);
         do_op(a, b, cin, s, co, lat, bc);
         n_vec++;
         if ({co, s} !== exp || lat != 8) begin
            n_err++;
            $display("FAIL random_%0d: a=%h b=%h cin=%b sub=%b got %h lat=%0d, want %h lat=8",
                     i, a, b, cin, cur_sub, {co, s}, lat, exp);
         end
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) tick();
      end
      cur_sub = 1'b0;
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_sub;
      logic [7:0] ta [3] = '{8'h10, 8'h01, 8'h01};
      logic [7:0] tb [3] = '{8'h01, 8'h02, 8'h02};
      logic       tc [3] = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         logic [7:0] s;
         logic       co;
         int         lat, bc;
         logic [8:0] exp;
         cur_sub = 1'b1;
         exp     = model(ta[i], tb[i], tc[i], 1'b1);
         do_op(ta[i], tb[i], tc[i], s, co, lat, bc);
         n_vec++;
         if ({co, s} !== exp) begin
            n_err++;
            $display("FAIL sub_%0d: {cout,sum}=%h, want %h", i, {co, s}, exp);
         end
      end
      cur_sub = 1'b0;
   endtask
`endif

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      bus.sub   = 1'b0;
`endif
      test_reset();
      test_basic_add();
      test_carry();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid();
`ifdef SERIAL_ADDER_SUB_EN
      test_sub();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
